// File: rtl/rr_index_encoder_pkg.sv
// Shared decoder-family definitions: line count, index width and the
// round-robin encoder state type.
package rr_index_encoder_pkg;

  localparam int N_LINES = 8;
  localparam int IDX_W   = $clog2(N_LINES);

  typedef enum logic {
    IDLE,
    ISSUE
  } rr_state_t;

endpackage

// File: rtl/rr_index_encoder_if.sv
// Valid/ready index channel between the round-robin encoder and the decoder.
interface rr_index_encoder_if
  import rr_index_encoder_pkg::*;
#(
  parameter int W = IDX_W
);

  logic [W-1:0] idx_out;
  logic         idx_valid;
  logic         idx_ready;

  modport master (output idx_out, output idx_valid, input idx_ready);
  modport slave  (input idx_out, input idx_valid, output idx_ready);

endinterface

// File: rtl/rr_index_encoder_pick.sv
// Round-robin pick: finds the first set bit of mask at or above ptr,
// wrapping from N-1 back to 0.
module rr_pick
  import rr_index_encoder_pkg::*;
#(
  parameter int N = N_LINES,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] ptr,
  output logic         hit,
  output logic [W-1:0] idx
);

  logic [N-1:0] rot;
  logic [W-1:0] off;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // through the loop can leave it unassigned and infer a latch.
  always_comb begin
    rot = '0;
    off = '0;
    hit = 1'b0;
    // rot[0] is the line at ptr; the W-bit add wraps because N == 2**W
    for (int i = 0; i < N; i++) begin
      rot[i] = mask[W'(i) + ptr];
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = W'(i);
        hit = 1'b1;
      end
    end
    idx = off + ptr;
  end

endmodule

// File: rtl/rr_index_encoder.sv
// Collects request pulses into a sticky pending mask and issues one granted
// index at a time over a valid/ready channel, round-robin from ptr.
module rr_index_encoder
  import rr_index_encoder_pkg::*;
#(
  parameter int N = N_LINES,
  parameter int W = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req_in,
  input  logic                flush,
  rr_index_encoder_if.master  io,
  output logic [N-1:0]        pending,
  output logic                busy
);

  rr_state_t    state;
  logic [W-1:0] ptr;
  logic [W-1:0] idx_q;
  logic         valid_q;

  logic [N-1:0] cand;
  logic [N-1:0] win_oh;
  logic [N-1:0] pend_load;
  logic [W-1:0] win;
  logic         hit;
  logic         xfer;

  assign cand   = pending | req_in;
  assign xfer   = valid_q & io.idx_ready;
  assign win_oh = N'(1) << win;
  // The granted bit leaves the mask unless it was both pending and pulsed
  // again this cycle: then one request is issued and the other re-pends.
  assign pend_load = (cand & ~win_oh) | (win_oh & pending & req_in);

  rr_pick #(.N(N), .W(W)) u_pick (
    .mask (cand),
    .ptr  (ptr),
    .hit  (hit),
    .idx  (win)
  );

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      ptr     <= '0;
    end else if (flush) begin
      state   <= IDLE;
      pending <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            state   <= ISSUE;
            valid_q <= 1'b1;
            idx_q   <= win;
            ptr     <= win + 1'b1;
            pending <= pend_load;
          end else begin
            pending <= cand;
          end
        end
        ISSUE: begin
          if (xfer && hit) begin
            idx_q   <= win;
            ptr     <= win + 1'b1;
            pending <= pend_load;
          end else if (xfer) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            pending <= cand;
          end else begin
            pending <= cand;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign io.idx_out   = idx_q;
  assign io.idx_valid = valid_q;
  assign busy         = valid_q | (|pending);

endmodule

// File: tb/tb_rr_index_encoder.sv
// Directed and randomized checks of rr_index_encoder against a behavioural
// model of pending requests, round-robin pointer and the held index.
module tb_rr_index_encoder;
  import rr_index_encoder_pkg::*;

  localparam int N = N_LINES;
  localparam int W = IDX_W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req_in;
  logic         flush;
  logic [N-1:0] pending;
  logic         busy;

  rr_index_encoder_if #(.W(W)) io ();

  rr_index_encoder #(.N(N), .W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_in  (req_in),
    .flush   (flush),
    .io      (io),
    .pending (pending),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  bit m_pend [N];
  int m_ptr;
  bit m_valid;
  int m_idx;

  int dut_cnt [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] m_mask();
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = m_pend[i];
    return m;
  endfunction

  task automatic check_state();
    check("valid", 32'(io.idx_valid), 32'(m_valid));
    if (m_valid) check("idx", 32'(io.idx_out), 32'(m_idx));
    check("pending", 32'(pending), 32'(m_mask()));
    check("busy", 32'(busy), 32'(m_valid || (m_mask() != '0)));
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    m_ptr   = 0;
    m_valid = 1'b0;
    m_idx   = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic f, input logic rd);
    bit cand [N];
    bit found;
    int win;
    if (f) begin
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      m_valid = 1'b0;
      m_idx   = 0;
      return;
    end
    for (int i = 0; i < N; i++) cand[i] = m_pend[i] | r[i];
    if (!m_valid || rd) begin
      found = 1'b0;
      win   = 0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!found && cand[j]) begin
          found = 1'b1;
          win   = j;
        end
      end
      if (found) begin
        bit keep;
        keep = m_pend[win] & r[win];
        for (int i = 0; i < N; i++) m_pend[i] = cand[i];
        m_pend[win] = keep;
        m_valid = 1'b1;
        m_idx   = win;
        m_ptr   = (win + 1) % N;
      end else begin
        m_valid = 1'b0;
        for (int i = 0; i < N; i++) m_pend[i] = cand[i];
      end
    end else begin
      for (int i = 0; i < N; i++) m_pend[i] = cand[i];
    end
  endtask

  // One clock: check outputs, drive inputs, advance DUT and model.
  task automatic cycle(input logic [N-1:0] r, input logic f, input logic rd);
    check_state();
    req_in       = r;
    flush        = f;
    io.idx_ready = rd;
    if (io.idx_valid && rd) dut_cnt[io.idx_out]++;
    @(posedge clk);
    #1;
    model_step(r, f, rd);
  endtask

  task automatic do_reset();
    req_in       = '0;
    flush        = 1'b0;
    io.idx_ready = 1'b0;
    rst_n        = 1'b0;
    #2;
    model_reset();
    check("rst_valid", 32'(io.idx_valid), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cnt();
    for (int i = 0; i < N; i++) dut_cnt[i] = 0;
  endtask

  initial begin
    rst_n        = 1'b1;
    req_in       = '0;
    flush        = 1'b0;
    io.idx_ready = 1'b0;
    clear_cnt();
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // 1: reset asserted mid-ISSUE with pending = A5
    cycle(8'h02, 1'b0, 1'b0);
    cycle(8'hA5, 1'b0, 1'b0);
    check("t1_valid_pre", 32'(io.idx_valid), 32'd1);
    check("t1_pend_pre", 32'(pending), 32'hA5);
    do_reset();

    // 2: single request, then ptr must sit at 6
    cycle(8'h20, 1'b0, 1'b1);
    check("t2_valid", 32'(io.idx_valid), 32'd1);
    check("t2_idx", 32'(io.idx_out), 32'd5);
    cycle(8'h00, 1'b0, 1'b1);
    check("t2_idle", 32'(io.idx_valid), 32'd0);
    cycle(8'h41, 1'b0, 1'b1);
    check("t2_ptr6", 32'(io.idx_out), 32'd6);
    cycle(8'h00, 1'b0, 1'b1);
    cycle(8'h00, 1'b0, 1'b1);

    // 3: all lines at once, back-to-back issue
    do_reset();
    cycle(8'hFF, 1'b0, 1'b1);
    for (int k = 0; k < N; k++) begin
      check("t3_valid", 32'(io.idx_valid), 32'd1);
      check("t3_idx", 32'(io.idx_out), 32'(k));
      cycle(8'h00, 1'b0, 1'b1);
    end
    check("t3_done", 32'(io.idx_valid), 32'd0);

    // 4: backpressure holds the output stable
    do_reset();
    cycle(8'h81, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      check("t4_hold_idx", 32'(io.idx_out), 32'd0);
      check("t4_hold_pend", 32'(pending), 32'h80);
      cycle(8'h00, 1'b0, 1'b0);
    end
    check("t4_first", 32'(io.idx_out), 32'd0);
    cycle(8'h00, 1'b0, 1'b1);
    check("t4_second", 32'(io.idx_out), 32'd7);
    cycle(8'h00, 1'b0, 1'b1);
    check("t4_done", 32'(io.idx_valid), 32'd0);

    // 5: re-pulse of the line being transferred is issued once more
    do_reset();
    clear_cnt();
    cycle(8'h08, 1'b0, 1'b0);
    cycle(8'h08, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cycle(8'h00, 1'b0, 1'b1);
    check("t5_issues_of_3", 32'(dut_cnt[3]), 32'd2);

    // 6: flush drops pending, output and same-cycle requests
    do_reset();
    cycle(8'h02, 1'b0, 1'b0);
    cycle(8'h3C, 1'b0, 1'b0);
    check("t6_pend_pre", 32'(pending), 32'h3C);
    clear_cnt();
    cycle(8'h01, 1'b1, 1'b0);
    check("t6_valid", 32'(io.idx_valid), 32'd0);
    check("t6_pending", 32'(pending), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 3; k++) cycle(8'h00, 1'b0, 1'b1);
    check("t6_no_idx0", 32'(dut_cnt[0]), 32'd0);

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      logic [N-1:0] r;
      logic         f;
      logic         rd;
      r  = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      f  = ($urandom_range(0, 31) == 0);
      rd = ($urandom_range(0, 3) != 0);
      cycle(r, f, rd);
    end
    check_state();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
